hop_sched: RTL and testbench

HOP_SCHED -- requirements
Module: hop_sched

---
 rtl/hop_sched.sv | 160 ++++++++++++++++
 tb/tb_hop_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hop_sched.sv
// Frequency-hop sequencer: per hop, scan-load the hop code, then run sync and TX windows.
// Optional ld_ack timeout in LOAD is enabled by defining HOP_SCHED_TIMEOUT_EN.
module hop_sched #(
  parameter int                     PHASE_WIDTH  = 24,
  parameter int                     CODE_WIDTH   = 32,
  parameter int                     NUM_HOPS     = 64,
  parameter int                     IDX_WIDTH    = 6,
  parameter int                     CNT_WIDTH    = 24,
  parameter logic [PHASE_WIDTH-1:0] START_PH_INC = 24'hC00000,
  parameter int                     HOP_DPH_INC  = 131072,
  parameter int                     ACK_TIMEOUT  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_WIDTH-1:0]   sync_len,
  input  logic [CNT_WIDTH-1:0]   dwell_len,
  input  logic                   tbl_wr_en,
  input  logic [IDX_WIDTH-1:0]   tbl_wr_addr,
  input  logic [CODE_WIDTH-1:0]  tbl_wr_data,
  output logic                   ld_req,
  output logic [CODE_WIDTH-1:0]  ld_code,
  input  logic                   ld_ack,
  output logic [IDX_WIDTH-1:0]   hop_idx,
  output logic [PHASE_WIDTH-1:0] hop_ph_inc,
  output logic                   sync_out,
  output logic                   tx_en,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYNC, S_TX, S_NEXT} state_t;

  state_t                  state;
  logic [CODE_WIDTH-1:0]   tbl [NUM_HOPS];
  logic [CNT_WIDTH-1:0]    cnt;
  logic [CNT_WIDTH-1:0]    sync_ld, dwell_ld;
  logic [IDX_WIDTH-1:0]    idx_nxt;
  logic                    last_hop;

`ifdef HOP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Zero length still yields a one-cycle window, so the reload value saturates at 0.
  assign sync_ld  = (sync_len  == '0) ? '0 : sync_len  - 1'b1;
  assign dwell_ld = (dwell_len == '0) ? '0 : dwell_len - 1'b1;
  assign idx_nxt  = hop_idx + 1'b1;
  assign last_hop = 32'(hop_idx) >= NUM_HOPS - 1;

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_wr_en && (32'(tbl_wr_addr) < NUM_HOPS))
      tbl[tbl_wr_addr] <= tbl_wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hop_idx    <= '0;
      hop_ph_inc <= START_PH_INC;
      ld_code    <= '0;
      ld_req     <= 1'b0;
      sync_out   <= 1'b0;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
`ifdef HOP_SCHED_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      seq_done <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        ld_req     <= 1'b0;
        sync_out   <= 1'b0;
        tx_en      <= 1'b0;
        busy       <= 1'b0;
        hop_idx    <= '0;
        hop_ph_inc <= START_PH_INC;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state      <= S_LOAD;
              hop_idx    <= '0;
              hop_ph_inc <= START_PH_INC;
              ld_code    <= tbl[0];
              ld_req     <= 1'b1;
              busy       <= 1'b1;
              err        <= 1'b0;
`ifdef HOP_SCHED_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end
          end
          S_LOAD: begin
            if (ld_ack) begin
              state    <= S_SYNC;
              ld_req   <= 1'b0;
              sync_out <= 1'b1;
              cnt      <= sync_ld;
            end
`ifdef HOP_SCHED_TIMEOUT_EN
            else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
              state  <= S_IDLE;
              ld_req <= 1'b0;
              busy   <= 1'b0;
              err    <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          S_SYNC: begin
            if (cnt == '0) begin
              state    <= S_TX;
              sync_out <= 1'b0;
              tx_en    <= 1'b1;
              cnt      <= dwell_ld;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_TX: begin
            if (cnt == '0) begin
              state <= S_NEXT;
              tx_en <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          S_NEXT: begin
            if (!last_hop) begin
              state      <= S_LOAD;
              hop_idx    <= idx_nxt;
              hop_ph_inc <= hop_ph_inc + PHASE_WIDTH'(HOP_DPH_INC);
              ld_code    <= tbl[idx_nxt];
              ld_req     <= 1'b1;
`ifdef HOP_SCHED_TIMEOUT_EN
              tmo_cnt    <= '0;
`endif
            end else begin
              state    <= S_IDLE;
              seq_done <= 1'b1;
              busy     <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hop_sched.sv
// Bench for hop_sched: vector table, hand-written corner sequences and random runs vs a hop-level model.
// Timeout checks follow HOP_SCHED_TIMEOUT_EN like the design.
module tb_hop_sched;

  localparam int NH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [23:0] sync_len = '0, dwell_len = '0;
  logic        tbl_wr_en = 1'b0;
  logic [1:0]  tbl_wr_addr = '0;
  logic [31:0] tbl_wr_data = '0;
  logic        ld_req, ld_ack = 1'b0;
  logic [31:0] ld_code;
  logic [1:0]  hop_idx;
  logic [23:0] hop_ph_inc;
  logic        sync_out, tx_en, busy, seq_done, err;

  logic        w_start = 1'b0;
  logic        w_ld_req, w_sync, w_tx, w_busy, w_done, w_err;
  logic [31:0] w_code;
  logic [0:0]  w_idx;
  logic [23:0] w_ph;

  always #5 clk = ~clk;

  hop_sched #(.NUM_HOPS(NH), .IDX_WIDTH(2), .ACK_TIMEOUT(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .sync_len(sync_len), .dwell_len(dwell_len),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .ld_req(ld_req), .ld_code(ld_code), .ld_ack(ld_ack),
    .hop_idx(hop_idx), .hop_ph_inc(hop_ph_inc), .sync_out(sync_out), .tx_en(tx_en),
    .busy(busy), .seq_done(seq_done), .err(err));

  // Two-hop instance for phase wrap; it acknowledges its own loads.
  hop_sched #(.NUM_HOPS(2), .IDX_WIDTH(1), .START_PH_INC(24'hFF0000), .HOP_DPH_INC(32'h020000)) u_wrap (
    .clk(clk), .reset(reset), .start(w_start), .abort(1'b0),
    .sync_len(sync_len), .dwell_len(dwell_len),
    .tbl_wr_en(1'b0), .tbl_wr_addr(1'b0), .tbl_wr_data(32'h0),
    .ld_req(w_ld_req), .ld_code(w_code), .ld_ack(w_ld_req),
    .hop_idx(w_idx), .hop_ph_inc(w_ph), .sync_out(w_sync), .tx_en(w_tx),
    .busy(w_busy), .seq_done(w_done), .err(w_err));

  int n_checks = 0, n_errors = 0;
  logic [31:0] tbl_m [NH];

  // Observations, one record per ld_req rising edge
  int          nobs, n_done, overlap, ack_dly, req_cnt;
  logic        prev_req = 1'b0, w_prev = 1'b0;
  logic [31:0] obs_code [8];
  int          obs_idx [8], obs_sync [8], obs_tx [8];
  logic [23:0] obs_ph [8];
  int          w_n, w_ndone;
  logic [23:0] w_obs_ph [4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] ph_model(input int base, input int step, input int h);
    return 24'((base + h * step) % (1 << 24));
  endfunction

  task automatic clear_obs();
    nobs = 0; n_done = 0; overlap = 0; w_n = 0; w_ndone = 0;
    for (int i = 0; i < 8; i++) begin obs_sync[i] = 0; obs_tx[i] = 0; end
  endtask

  // One cycle: clear pulses, sample outputs, act as the scan loader.
  task automatic tick();
    @(negedge clk);
    start = 1'b0; abort = 1'b0; tbl_wr_en = 1'b0; w_start = 1'b0;
    if (sync_out && tx_en) overlap++;
    if (ld_req && !prev_req && nobs < 8) begin
      obs_code[nobs] = ld_code; obs_idx[nobs] = int'(hop_idx); obs_ph[nobs] = hop_ph_inc; nobs++;
    end
    if (sync_out && nobs > 0) obs_sync[nobs-1]++;
    if (tx_en && nobs > 0) obs_tx[nobs-1]++;
    if (seq_done) n_done++;
    prev_req = ld_req;
    if (w_ld_req && !w_prev && w_n < 4) begin w_obs_ph[w_n] = w_ph; w_n++; end
    if (w_done) w_ndone++;
    w_prev = w_ld_req;
    if (ld_req && ack_dly != 0) begin
      req_cnt++;
      ld_ack = (req_cnt == ack_dly);
    end else begin
      req_cnt = 0;
      ld_ack = 1'b0;
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    tbl_wr_en = 1'b1; tbl_wr_addr = 2'(a); tbl_wr_data = d; tbl_m[a] = d;
    tick();
  endtask

  // Full sequence run; the sync_len applied during hop 0's sync window is smid.
  task automatic run_seq(input string tag, input int s, input int d, input int a, input int smid,
                         input int es0, input int esr, input int etx);
    bit done = 0;
    clear_obs();
    sync_len = 24'(s); dwell_len = 24'(d); ack_dly = a;
    start = 1'b1;
    for (int c = 0; c < 2000 && !done; c++) begin
      tick();
      if (nobs == 1 && sync_out) sync_len = 24'(smid);
      if (seq_done) begin done = 1; chk({tag, "_busy_at_done"}, 64'(busy), 0); end
    end
    chk({tag, "_finished"}, 64'(done), 1);
    tick(); tick();
    chk({tag, "_hops"}, 64'(nobs), NH);
    for (int h = 0; h < NH; h++) begin
      chk($sformatf("%s_code%0d", tag, h), 64'(obs_code[h]), 64'(tbl_m[h]));
      chk($sformatf("%s_idx%0d", tag, h), 64'(obs_idx[h]), 64'(h));
      chk($sformatf("%s_ph%0d", tag, h), 64'(obs_ph[h]), 64'(ph_model(32'hC00000, 131072, h)));
      chk($sformatf("%s_sync%0d", tag, h), 64'(obs_sync[h]), 64'((h == 0) ? es0 : esr));
      chk($sformatf("%s_tx%0d", tag, h), 64'(obs_tx[h]), 64'(etx));
    end
    chk({tag, "_done_pulses"}, 64'(n_done), 1);
    chk({tag, "_overlap"}, 64'(overlap), 0);
  endtask

  typedef struct {
    int s, d, a, smid;
    int e_s0, e_srest, e_tx;
  } vec_t;

  initial begin
    vec_t vecs [5];
    bit   found, p1, p2, chkd, done;
    logic [31:0] old;
    int   s, d, cnt;

    vecs[0] = '{3, 5, 2, 3, 3, 3, 5};
    vecs[1] = '{0, 0, 1, 0, 1, 1, 1};
    vecs[2] = '{1, 1, 3, 1, 1, 1, 1};
    vecs[3] = '{3, 2, 1, 6, 3, 6, 2};
    vecs[4] = '{4, 0, 2, 0, 4, 1, 1};
    ack_dly = 0; req_cnt = 0;
    clear_obs();

    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_hop_idx", 64'(hop_idx), 0);
    chk("rst_ph", 64'(hop_ph_inc), 64'h00C00000);
    chk("rst_ld_code", 64'(ld_code), 0);
    chk("rst_ctrl", 64'({ld_req, sync_out, tx_en, busy, seq_done, err}), 0);
    chk("rst_wrap_ph", 64'(w_ph), 64'h00FF0000);

    wr(0, 32'hA0A0_0001); wr(1, 32'hB0B0_0002); wr(2, 32'hC0C0_0003); wr(3, 32'hD0D0_0004);

    for (int i = 0; i < 5; i++)
      run_seq($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].a, vecs[i].smid,
              vecs[i].e_s0, vecs[i].e_srest, vecs[i].e_tx);

    // start with abort in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    chk("sa_busy", 64'(busy), 0);
    chk("sa_ld_req", 64'(ld_req), 0);
    tick();
    chk("sa_busy2", 64'(busy), 0);

    // start during TX ignored; table write during LOAD leaves latched code alone
    clear_obs();
    sync_len = 24'd2; dwell_len = 24'd3; ack_dly = 3;
    p1 = 0; p2 = 0; chkd = 0; done = 0; old = '0;
    start = 1'b1;
    for (int c = 0; c < 1000 && !done; c++) begin
      tick();
      if (p2 && !chkd) begin chk("ld_code_hold", 64'(ld_code), 64'(old)); chkd = 1; end
      if (!p1 && tx_en && hop_idx == 2'd1) begin start = 1'b1; p1 = 1; end
      if (!p2 && ld_req && hop_idx == 2'd2) begin
        old = tbl_m[2];
        tbl_wr_en = 1'b1; tbl_wr_addr = 2'd2; tbl_wr_data = ~old; tbl_m[2] = ~old;
        p2 = 1;
      end
      if (seq_done) done = 1;
    end
    tick();
    chk("stx_done", 64'(done), 1);
    chk("stx_hops", 64'(nobs), NH);
    chk("stx_done_pulses", 64'(n_done), 1);
    chk("stx_code2", 64'(obs_code[2]), 64'(old));

    // abort in TX of hop 2, then restart from hop 0
    clear_obs();
    sync_len = 24'd2; dwell_len = 24'd4; ack_dly = 2;
    start = 1'b1;
    found = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      tick();
      if (tx_en && hop_idx == 2'd2) found = 1;
    end
    chk("abort_reach_tx2", 64'(found), 1);
    abort = 1'b1;
    tick();
    chk("abort_ctrl", 64'({ld_req, sync_out, tx_en, busy, seq_done}), 0);
    repeat (10) tick();
    chk("abort_no_done", 64'(n_done), 0);
    chk("abort_idle", 64'({ld_req, busy}), 0);
    clear_obs();
    start = 1'b1;
    for (int c = 0; c < 20 && nobs == 0; c++) tick();
    chk("restart_idx", 64'(obs_idx[0]), 0);
    chk("restart_code", 64'(obs_code[0]), 64'(tbl_m[0]));
    chk("restart_ph", 64'(obs_ph[0]), 64'h00C00000);
    abort = 1'b1;
    tick();

    // random runs against the hop-level model
    for (int r = 0; r < 6; r++) begin
      for (int h = 0; h < NH; h++) wr(h, $urandom);
      s = $urandom_range(0, 6);
      d = $urandom_range(0, 6);
      run_seq($sformatf("rnd%0d", r), s, d, $urandom_range(1, 4), s,
              (s == 0) ? 1 : s, (s == 0) ? 1 : s, (d == 0) ? 1 : d);
    end

    // phase-increment wrap on the two-hop instance
    clear_obs();
    sync_len = 24'd1; dwell_len = 24'd1;
    w_start = 1'b1;
    for (int c = 0; c < 200 && w_ndone == 0; c++) tick();
    chk("wrap_hops", 64'(w_n), 2);
    chk("wrap_ph0", 64'(w_obs_ph[0]), 64'h00FF0000);
    chk("wrap_ph1", 64'(w_obs_ph[1]), 64'h00010000);
    chk("wrap_done", 64'(w_ndone), 1);

    // missing ld_ack
    ack_dly = 0;
    start = 1'b1;
`ifdef HOP_SCHED_TIMEOUT_EN
    tick();
    cnt = 0;
    for (int c = 0; c < 100 && ld_req; c++) begin cnt++; tick(); end
    chk("tmo_load_cycles", 64'(cnt), 16);
    chk("tmo_err", 64'(err), 1);
    chk("tmo_busy", 64'(busy), 0);
    ack_dly = 2;
    start = 1'b1;
    tick();
    chk("tmo_err_clr", 64'(err), 0);
`else
    repeat (1000) tick();
    chk("noack_ld_req", 64'(ld_req), 1);
    chk("noack_err", 64'(err), 0);
    chk("noack_busy", 64'(busy), 1);
`endif
    abort = 1'b1;
    tick();
    chk("final_idle", 64'({ld_req, busy}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
